// File: rtl/cmd_wb_master_pkg.sv
// cmd_wb_master_pkg
// Shared constants for the command-byte Wishbone master:
//   - status codes returned to the host after every command
//   - command byte field positions
//   - FSM state encodings
//   - a small decode helper for the reserved command bits
package cmd_wb_master_pkg;

  // Status codes sent back on the transmit path
  localparam logic [7:0] CMD_ST_OK      = 8'h00;
  localparam logic [7:0] CMD_ST_TIMEOUT = 8'h01;
  localparam logic [7:0] CMD_ST_BADCMD  = 8'h02;

  // Command byte layout: [7] write, [6:4] reserved (must be 0), [3:0] address
  localparam int CMD_WE_BIT  = 7;
  localparam int CMD_RSV_MSB = 6;
  localparam int CMD_RSV_LSB = 4;
  localparam int CMD_ADR_MSB = 3;
  localparam int CMD_ADR_LSB = 0;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_DATA  = 3'd1;
  localparam logic [2:0] ST_WB_REQ    = 3'd2;
  localparam logic [2:0] ST_TX_STATUS = 3'd3;
  localparam logic [2:0] ST_TX_DATA   = 3'd4;

  // A command is malformed when any reserved bit is set
  function automatic logic cmd_is_bad(input logic [7:0] cmd);
    return cmd[CMD_RSV_MSB:CMD_RSV_LSB] != 3'b000;
  endfunction

endpackage

// File: rtl/cmd_wb_master.sv
// cmd_wb_master
// Byte-stream command interpreter acting as the sole Wishbone master of the
// glitch register block. One command byte (plus one data byte for writes)
// produces one 8-bit bus cycle and a status byte (plus a data byte for
// successful reads) on the transmit path.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rx_data/valid/ready     incoming command/data byte stream
//   tx_data/valid/ready     outgoing status/data byte stream
//   adr_o, dat_o, dat_i,
//   we_o, stb_o, ack_i      Wishbone master signals (4-bit address space)
//   busy                    high whenever the FSM is not in IDLE
//
// Parameter:
//   TIMEOUT                 max stb_o cycles without ack_i (1..65535)
module cmd_wb_master
  import cmd_wb_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  output logic       we_o,
  output logic       stb_o,
  input  logic       ack_i,
  output logic       busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  // Value held during the final permitted stb_o cycle: a miss here
  // brings the count to TIMEOUT and aborts the transfer.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [7:0]       status;
  logic [7:0]       rd_data;
  logic [CNT_W-1:0] to_cnt;

  // Counter saturates at TIMEOUT so it can never wrap back into range
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  // ---- control / datapath registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      adr_o   <= '0;
      dat_o   <= '0;
      we_o    <= 1'b0;
      rd_data <= '0;
      status  <= CMD_ST_OK;
      to_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (cmd_is_bad(rx_data)) begin
              status <= CMD_ST_BADCMD;
              state  <= ST_TX_STATUS;
            end else begin
              adr_o  <= rx_data[CMD_ADR_MSB:CMD_ADR_LSB];
              we_o   <= rx_data[CMD_WE_BIT];
              to_cnt <= '0;
              state  <= rx_data[CMD_WE_BIT] ? ST_GET_DATA : ST_WB_REQ;
            end
          end
        end
        ST_GET_DATA: begin
          if (rx_valid) begin
            dat_o  <= rx_data;
            to_cnt <= '0;
            state  <= ST_WB_REQ;
          end
        end
        ST_WB_REQ: begin
          // ack_i takes priority over a simultaneous timeout
          if (ack_i) begin
            rd_data <= dat_i;
            status  <= CMD_ST_OK;
            state   <= ST_TX_STATUS;
          end else begin
            to_cnt <= sat_inc(to_cnt);
            if (to_cnt == CNT_LAST) begin
              status <= CMD_ST_TIMEOUT;
              state  <= ST_TX_STATUS;
            end
          end
        end
        ST_TX_STATUS: begin
          if (tx_ready)
            state <= (!we_o && status == CMD_ST_OK) ? ST_TX_DATA : ST_IDLE;
        end
        ST_TX_DATA: begin
          if (tx_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- outputs decoded from registered state ----
  // Because the state register resets asynchronously, stb_o and tx_valid
  // drop in the same cycle rst_i rises.
  assign stb_o    = (state == ST_WB_REQ);
  assign tx_valid = (state == ST_TX_STATUS) || (state == ST_TX_DATA);
  assign rx_ready = (state == ST_IDLE) || (state == ST_GET_DATA);
  assign busy     = (state != ST_IDLE);
  assign tx_data  = (state == ST_TX_STATUS) ? status  :
                    (state == ST_TX_DATA)   ? rd_data : 8'h00;

endmodule

// File: tb/tb_cmd_wb_master.sv
module tb_cmd_wb_master;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       we_o;
  logic       stb_o;
  logic       ack_i;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  cmd_wb_master #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .we_o(we_o), .stb_o(stb_o), .ack_i(ack_i), .busy(busy)
  );

  // Slave model: mode 0 acks at once, 1 never acks, 2 acks on stb cycle ack_at
  logic [7:0] regs [16];
  logic [1:0] mode = 2'd0;
  int         ack_at = 1;
  int         stb_cyc = 0;
  logic       tb_clr = 1'b1;

  assign ack_i = stb_o && ((mode == 2'd0) || (mode == 2'd2 && stb_cyc == ack_at - 1));
  assign dat_i = regs[adr_o];

  always @(posedge clk_i) begin
    if (stb_o) stb_cyc <= stb_cyc + 1;
    else       stb_cyc <= 0;
    if (tb_clr) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else if (stb_o && ack_i && we_o) begin
      regs[adr_o] <= dat_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected tx bytes, popped by the monitor on each handshake
  logic [7:0] exp_q [$];
  int stb_run = 0;
  int last_stb_len = 0;
  int stb_pulses = 0;

  always @(negedge clk_i) begin
    if (!rst_i && tx_valid && tx_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_data, e);
        end
      end
    end
    if (stb_o) stb_run++;
    else if (stb_run != 0) begin
      last_stb_len = stb_run;
      stb_pulses++;
      stb_run = 0;
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (rx_ready) begin ok = 1; break; end
    end
    @(posedge clk_i); #1;
    rx_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL rx_accept: byte 0x%0h never accepted", b);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    @(posedge clk_i); #1;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: timed out, %0d bytes pending, busy=%0d", name, exp_q.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    rst_i = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_stb", stb_o, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_adr_dat_txd", {adr_o, dat_o, tx_data, we_o}, 0);
    tb_clr = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Write 0x5A to register 1
    exp_q.push_back(8'h00);
    send_byte(8'h81);
    send_byte(8'h5A);
    @(negedge clk_i);
    check("wr_stb", stb_o, 1);
    check("wr_we", we_o, 1);
    check("wr_adr", adr_o, 4'h1);
    check("wr_dat", dat_o, 8'h5A);
    @(posedge clk_i); #1;
    wait_idle("write");

    // Read register 1
    exp_q.push_back(8'h00); exp_q.push_back(8'h5A);
    send_byte(8'h01);
    wait_idle("read");

    // Bad command: status only, no bus cycle, then a normal read
    p = stb_pulses;
    exp_q.push_back(8'h02);
    send_byte(8'h91);
    wait_idle("badcmd");
    check("bad_no_stb", stb_pulses - p, 0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h5A);
    send_byte(8'h01);
    wait_idle("read_after_bad");

    // Timeout: slave never acks
    mode = 2'd1;
    exp_q.push_back(8'h01);
    send_byte(8'h02);
    wait_idle("timeout");
    check("timeout_stb_len", last_stb_len, 4);

    // ack on the final permitted cycle wins
    mode = 2'd2; ack_at = 4;
    exp_q.push_back(8'h00); exp_q.push_back(8'h5A);
    send_byte(8'h01);
    wait_idle("ack_boundary");
    check("boundary_stb_len", last_stb_len, 4);
    mode = 2'd0;

    // Backpressure on both response bytes
    tx_ready = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h5A);
    send_byte(8'h01);
    for (int n = 0; n < 50 && !tx_valid; n++) @(negedge clk_i);
    for (int i = 0; i < 10; i++) begin
      check("bp_status_hold", {tx_valid, tx_data}, {1'b1, 8'h00});
      check("bp_rx_ready_st", rx_ready, 0);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    tx_ready = 1'b1;
    @(posedge clk_i); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("bp_data_hold", {tx_valid, tx_data}, {1'b1, 8'h5A});
      check("bp_rx_ready_dt", rx_ready, 0);
    end
    @(posedge clk_i); #1;
    tx_ready = 1'b1;
    wait_idle("backpressure");

    // Reset in the middle of a write
    send_byte(8'h81);
    check("pre_rst_busy", busy, 1);
    rst_i = 1'b1;
    #1;
    check("midrst_stb_txv_busy", {stb_o, tx_valid, busy}, 0);
    check("midrst_adr_dat_we", {adr_o, dat_o, we_o}, 0);
    check("midrst_txd", tx_data, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h5A);
    send_byte(8'h01);
    wait_idle("read_after_reset");

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
